// File: rtl/reg_seq_pkg.sv
// Shared constants, opcode map and FSM state type for the register-file sequencer.
package reg_seq_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned INSTR_W = 16;

  // Instruction field positions (imm8 overlaps SA/SB; only LDI uses it)
  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned DR_LSB  = 9;
  localparam int unsigned SA_LSB  = 6;
  localparam int unsigned SB_LSB  = 3;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [OP_W-1:0] OP_NOP = 4'd0;
  localparam logic [OP_W-1:0] OP_ADD = 4'd1;
  localparam logic [OP_W-1:0] OP_SUB = 4'd2;
  localparam logic [OP_W-1:0] OP_AND = 4'd3;
  localparam logic [OP_W-1:0] OP_OR  = 4'd4;
  localparam logic [OP_W-1:0] OP_XOR = 4'd5;
  localparam logic [OP_W-1:0] OP_MOV = 4'd6;
  localparam logic [OP_W-1:0] OP_LDI = 4'd7;
  localparam logic [OP_W-1:0] OP_SHL = 4'd8;
  localparam logic [OP_W-1:0] OP_SHR = 4'd9;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_e;

  function automatic logic op_writes(input logic [OP_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_SHR);
  endfunction

  function automatic logic op_illegal(input logic [OP_W-1:0] op);
    return op > OP_SHR;
  endfunction

  function automatic logic op_sets_carry(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu8.sv
// Combinational 8-bit ALU; carry is carry-out for ADD and borrow for SUB.
module alu8
  import reg_seq_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              carry
);

  logic [DATA_W:0] wide;

  always_comb begin
    wide   = '0;
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[DATA_W-1:0];
        carry  = wide[DATA_W];
      end
      OP_SUB: begin
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[DATA_W-1:0];
        carry  = wide[DATA_W];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_MOV:  result = a;
      OP_LDI:  result = imm;
      OP_SHL:  result = {a[DATA_W-2:0], 1'b0};
      OP_SHR:  result = {1'b0, a[DATA_W-1:1]};
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/reg_seq_ctrl.sv
// Four-cycle instruction sequencer driving the 8x8 register file:
// accept, read operands, execute, write back.
module reg_seq_ctrl
  import reg_seq_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic [INSTR_W-1:0] INSTR,
  input  logic               INSTR_VALID,
  output logic               INSTR_READY,
  output logic [SEL_W-1:0]   SA,
  output logic [SEL_W-1:0]   SB,
  input  logic [DATA_W-1:0]  OUTA,
  input  logic [DATA_W-1:0]  OUTB,
  output logic [SEL_W-1:0]   DR,
  output logic               LD,
  output logic [DATA_W-1:0]  D_out,
  output logic               DONE,
  output logic               ERR,
  output logic               FLAG_Z,
  output logic               FLAG_C
);

  state_e              state_q, state_d;
  logic [INSTR_W-1:0]  instr_q;
  logic [DATA_W-1:0]   opa_q, opb_q;
  logic [OP_W-1:0]     op_c;
  logic [DATA_W-1:0]   alu_res_c;
  logic                alu_z_c, alu_c_c;

  assign op_c = instr_q[OP_LSB +: OP_W];

  alu8 u_alu (
    .op     (op_c),
    .a      (opa_q),
    .b      (opb_q),
    .imm    (instr_q[IMM_LSB +: DATA_W]),
    .result (alu_res_c),
    .zero   (alu_z_c),
    .carry  (alu_c_c)
  );

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (INSTR_VALID) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the upcoming state so each pulse lands in its own cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      INSTR_READY <= 1'b1;
      instr_q     <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      SA          <= '0;
      SB          <= '0;
      DR          <= '0;
      LD          <= 1'b0;
      D_out       <= '0;
      DONE        <= 1'b0;
      ERR         <= 1'b0;
      FLAG_Z      <= 1'b0;
      FLAG_C      <= 1'b0;
    end else begin
      INSTR_READY <= (state_d == S_IDLE);
      LD          <= 1'b0;
      DONE        <= 1'b0;
      ERR         <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (INSTR_VALID) begin
            instr_q <= INSTR;
            SA      <= INSTR[SA_LSB +: SEL_W];
            SB      <= INSTR[SB_LSB +: SEL_W];
            DR      <= INSTR[DR_LSB +: SEL_W];
          end
        end
        S_READ: begin
          opa_q <= OUTA;
          opb_q <= OUTB;
        end
        S_EXEC: begin
          DONE <= 1'b1;
          ERR  <= op_illegal(op_c);
          if (op_writes(op_c)) begin
            LD     <= 1'b1;
            D_out  <= alu_res_c;
            FLAG_Z <= alu_z_c;
            if (op_sets_carry(op_c)) FLAG_C <= alu_c_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_seq_ctrl.sv
// Bench for reg_seq_ctrl: register file environment, transaction-level model,
// per-cycle compare, directed scenarios and randomized instruction stream.
module tb_reg_seq_ctrl;

  logic        CLK = 1'b0;
  logic        RESET, INSTR_VALID;
  logic [15:0] INSTR;
  logic        INSTR_READY, LD, DONE, ERR, FLAG_Z, FLAG_C;
  logic [2:0]  SA, SB, DR;
  logic [7:0]  OUTA, OUTB, D_out;

  reg_seq_ctrl dut (
    .CLK(CLK), .RESET(RESET), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY), .SA(SA), .SB(SB), .OUTA(OUTA), .OUTB(OUTB),
    .DR(DR), .LD(LD), .D_out(D_out), .DONE(DONE), .ERR(ERR),
    .FLAG_Z(FLAG_Z), .FLAG_C(FLAG_C)
  );

  always #5 CLK = ~CLK;

  // Register file environment, written by the DUT or by bench preloads
  logic [7:0] rf [8];
  logic       pl_we = 1'b0;
  logic [2:0] pl_idx = '0;
  logic [7:0] pl_val = '0;
  assign OUTA = rf[SA];
  assign OUTB = rf[SB];
  always @(posedge CLK) begin
    if (LD === 1'b1) rf[DR] <= D_out;
    if (pl_we) rf[pl_idx] <= pl_val;
  end

  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit armed = 1'b0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Transaction model: an accepted instruction occupies the three following cycles,
  // its write-back and flags appear in the third one.
  logic [7:0] mrf [8];
  int         phase = 0, acc_cyc = -100, prev_acc = -100, s;
  logic       e_ready, e_ld, e_done, e_err, e_z, e_c, m_cout;
  logic [2:0] e_sa, e_sb, e_dr;
  logic [7:0] e_dout, m_res, ma, mb;
  logic [3:0] m_op;

  always @(posedge CLK) begin
    cyc++;
    if (pl_we) mrf[pl_idx] = pl_val;
    if (RESET) begin
      phase = 0; armed = 1'b1;
      e_ready = 1'b1; e_ld = 1'b0; e_done = 1'b0; e_err = 1'b0;
      e_z = 1'b0; e_c = 1'b0; e_sa = '0; e_sb = '0; e_dr = '0; e_dout = '0;
    end else begin
      e_ld = 1'b0; e_done = 1'b0; e_err = 1'b0;
      if (phase == 3) phase = 0;
      else if (phase != 0) phase++;
      else if (INSTR_VALID === 1'b1) begin
        phase = 1; prev_acc = acc_cyc; acc_cyc = cyc;
        m_op = INSTR[15:12]; e_dr = INSTR[11:9]; e_sa = INSTR[8:6]; e_sb = INSTR[5:3];
        ma = mrf[e_sa]; mb = mrf[e_sb]; m_cout = 1'b0;
        case (m_op)
          4'd1: begin s = int'(ma) + int'(mb); m_res = 8'(s); m_cout = (s > 255); end
          4'd2: begin m_res = 8'(int'(ma) - int'(mb)); m_cout = (ma < mb); end
          4'd3: m_res = ma & mb;
          4'd4: m_res = ma | mb;
          4'd5: m_res = ma ^ mb;
          4'd6: m_res = ma;
          4'd7: m_res = INSTR[7:0];
          4'd8: m_res = 8'(int'(ma) * 2);
          4'd9: m_res = 8'(int'(ma) / 2);
          default: m_res = 8'd0;
        endcase
      end
      if (phase == 3) begin
        e_done = 1'b1;
        e_err  = (m_op >= 4'd10);
        if (m_op >= 4'd1 && m_op <= 4'd9) begin
          e_ld = 1'b1; e_dout = m_res; mrf[e_dr] = m_res; e_z = (m_res == 8'd0);
          if (m_op == 4'd1 || m_op == 4'd2) e_c = m_cout;
        end
      end
      e_ready = (phase == 0);
    end
  end

  always @(negedge CLK) begin
    if (armed) begin
      chk("INSTR_READY", 8'(INSTR_READY), 8'(e_ready));
      chk("SA", 8'(SA), 8'(e_sa));
      chk("SB", 8'(SB), 8'(e_sb));
      chk("DR", 8'(DR), 8'(e_dr));
      chk("LD", 8'(LD), 8'(e_ld));
      if (e_ld) chk("D_out", D_out, e_dout);
      chk("DONE", 8'(DONE), 8'(e_done));
      chk("ERR", 8'(ERR), 8'(e_err));
      chk("FLAG_Z", 8'(FLAG_Z), 8'(e_z));
      chk("FLAG_C", 8'(FLAG_C), 8'(e_c));
    end
  end

  function automatic logic [15:0] enc(input int op, input int d, input int a, input int b);
    return {4'(op), 3'(d), 3'(a), 3'(b), 3'b000};
  endfunction

  function automatic logic [15:0] ldi(input int d, input int imm);
    return {4'd7, 3'(d), 1'b0, 8'(imm)};
  endfunction

  task automatic preload(input logic [2:0] i, input logic [7:0] v);
    pl_we = 1'b1; pl_idx = i; pl_val = v;
    @(negedge CLK);
    pl_we = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (INSTR_READY !== 1'b1 && n < 16) begin @(negedge CLK); n++; end
    if (n >= 16) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout: got %b, expected 1 (cycle %0d)", INSTR_READY, cyc);
    end
  endtask

  // Returns at the negedge of the READ cycle of the accepted instruction
  task automatic issue(input logic [15:0] ins, input bit hold);
    INSTR = ins; INSTR_VALID = 1'b1;
    wait_idle();
    @(negedge CLK);
    if (!hold) INSTR_VALID = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; INSTR_VALID = 1'b0; INSTR = '0;
    repeat (3) @(negedge CLK);
    chk("rst_ready", 8'(INSTR_READY), 8'd1);
    chk("rst_ld", 8'(LD), 8'd0);
    chk("rst_dout", D_out, 8'd0);
    RESET = 1'b0;
    for (int i = 0; i < 8; i++) preload(3'(i), 8'($urandom));
    preload(3'd1, 8'hF0);
    preload(3'd2, 8'h20);

    // LDI R3, 0x5A
    issue(ldi(3, 8'h5A), 1'b0);
    chk("ldi_ready_c1", 8'(INSTR_READY), 8'd0);
    @(negedge CLK);
    chk("ldi_ready_c2", 8'(INSTR_READY), 8'd0);
    @(negedge CLK);
    chk("ldi_ld", 8'(LD), 8'd1);
    chk("ldi_dr", 8'(DR), 8'd3);
    chk("ldi_dout", D_out, 8'h5A);
    chk("ldi_done", 8'(DONE), 8'd1);
    chk("ldi_z", 8'(FLAG_Z), 8'd0);
    chk("ldi_ready_c3", 8'(INSTR_READY), 8'd0);
    @(negedge CLK);
    chk("ldi_ready_c4", 8'(INSTR_READY), 8'd1);

    // ADD R4 = R1 + R2
    issue(enc(1, 4, 1, 2), 1'b0);
    chk("add_sa_c1", 8'(SA), 8'd1);
    chk("add_sb_c1", 8'(SB), 8'd2);
    repeat (2) @(negedge CLK);
    chk("add_dout", D_out, 8'h10);
    chk("add_c", 8'(FLAG_C), 8'd1);
    chk("add_z", 8'(FLAG_Z), 8'd0);
    chk("add_sa_c3", 8'(SA), 8'd1);
    chk("add_sb_c3", 8'(SB), 8'd2);

    // SUB R5 = R2 - R1 (borrow), then R0 = R1 - R1
    issue(enc(2, 5, 2, 1), 1'b0);
    repeat (2) @(negedge CLK);
    chk("sub_dout", D_out, 8'h30);
    chk("sub_c", 8'(FLAG_C), 8'd1);
    issue(enc(2, 0, 1, 1), 1'b0);
    repeat (2) @(negedge CLK);
    chk("subz_dout", D_out, 8'h00);
    chk("subz_z", 8'(FLAG_Z), 8'd1);
    chk("subz_c", 8'(FLAG_C), 8'd0);

    // Illegal opcode 0xC, then NOP: flags stay Z=1, C=0
    issue(enc(12, 3, 1, 2), 1'b0);
    repeat (2) @(negedge CLK);
    chk("ill_done", 8'(DONE), 8'd1);
    chk("ill_err", 8'(ERR), 8'd1);
    chk("ill_ld", 8'(LD), 8'd0);
    chk("ill_z", 8'(FLAG_Z), 8'd1);
    issue(enc(0, 3, 1, 2), 1'b0);
    repeat (2) @(negedge CLK);
    chk("nop_done", 8'(DONE), 8'd1);
    chk("nop_err", 8'(ERR), 8'd0);
    chk("nop_ld", 8'(LD), 8'd0);
    chk("nop_c", 8'(FLAG_C), 8'd0);

    // LDI R6 then MOV R7 <- R6 with valid held throughout
    @(negedge CLK);
    issue(ldi(6, 8'h07), 1'b1);
    issue(enc(6, 7, 6, 0), 1'b0);
    chk("b2b_spacing", 8'(acc_cyc - prev_acc), 8'd4);
    repeat (2) @(negedge CLK);
    chk("mov_ld", 8'(LD), 8'd1);
    chk("mov_dr", 8'(DR), 8'd7);
    chk("mov_dout", D_out, 8'h07);

    // ADD aborted by reset during EXEC
    @(negedge CLK);
    issue(enc(1, 2, 1, 2), 1'b0);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    chk("abort_ld", 8'(LD), 8'd0);
    chk("abort_done", 8'(DONE), 8'd0);
    chk("abort_sa", 8'(SA), 8'd0);
    chk("abort_dout", D_out, 8'd0);
    chk("abort_flagc", 8'(FLAG_C), 8'd0);
    RESET = 1'b0;
    @(negedge CLK);
    chk("abort_ready", 8'(INSTR_READY), 8'd1);
    repeat (4) @(negedge CLK);

    // Randomized instruction stream with occasional preloads and resets
    for (int k = 0; k < 200; k++) begin
      wait_idle();
      if ($urandom_range(3) == 0) preload(3'($urandom), 8'($urandom));
      repeat ($urandom_range(2)) @(negedge CLK);
      issue({4'($urandom_range(15)), 12'($urandom)}, 1'b0);
      if ($urandom_range(19) == 0) begin
        repeat ($urandom_range(2)) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
      end
    end
    repeat (6) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_seq_ctrl.md
# reg_seq_ctrl

Multi-cycle instruction sequencer that acts as the initiator for the 8×8-bit register file. It accepts one 16-bit instruction per handshake and drives the register file's read selects (SA, SB). It captures the returned operands (OUTA, OUTB), computes an 8-bit result, and issues a single write-back (DR, LD, D_out). It is the control/execute stage of the single-core processor, sitting between the instruction source and the register file.

## Interface
Parameters: none (widths fixed by the register file: 8-bit data, 3-bit selects, 16-bit instruction).

- CLK  in  1  rising-edge clock
- RESET  in  1  synchronous, active-high reset
- INSTR  in  16  instruction word, sampled on handshake
- INSTR_VALID  in  1  instruction present
- INSTR_READY  out  1  sequencer can accept (IDLE only)
- SA  out  3  register file read select A
- SB  out  3  register file read select B
- OUTA  in  8  register file read data A (combinational from SA)
- OUTB  in  8  register file read data B (combinational from SB)
- DR  out  3  register file write select
- LD  out  1  register file write enable, one-cycle pulse
- D_out  out  8  write data to register file D_in
- DONE  out  1  one-cycle pulse, instruction retired
- ERR  out  1  one-cycle pulse with DONE, illegal opcode
- FLAG_Z  out  1  registered zero flag of last ALU result
- FLAG_C  out  1  registered carry/borrow of last ADD/SUB

## Operation
- Instruction fields:
  - [15:12] opcode
  - [11:9] DR
  - [8:6] SA
  - [5:3] SB
  - [7:0] imm8 (LDI only)
- Opcodes:
  - 0 NOP
  - 1 ADD: A+B
  - 2 SUB: A−B
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 MOV: A
  - 7 LDI: imm8
  - 8 SHL: A<<1
  - 9 SHR: A>>1, logical
  - 10–15 illegal
- FSM states: IDLE → READ → EXEC → WB → IDLE.
  - IDLE: INSTR_READY=1. On INSTR_VALID, latch INSTR and go to READ.
  - READ: drive SA/SB from the latched instruction. At end of cycle, capture OUTA/OUTB into operand registers.
  - EXEC: compute result into a result register. Update FLAG_Z for every writing opcode. Update FLAG_C for ADD (carry-out) and SUB (borrow = A<B) only.
  - WB: LD=1 for writing opcodes with D_out=result and DR=latched DR. DONE=1.
- NOP and illegal opcodes: READ → EXEC → WB with LD=0. DONE=1; ERR=1 for illegal. Flags unchanged.
- Arithmetic is 8-bit modulo 2^8; the carry goes to FLAG_C only.
- SA, SB, and DR hold the latched values from READ through WB. They hold their last values in IDLE.
- LD is never asserted outside WB.

## Timing
- Handshake: transfer occurs on the rising edge with INSTR_VALID & INSTR_READY.
- Relative to the handshake edge at cycle 0:
  - READ is cycle 1.
  - EXEC is cycle 2.
  - WB is cycle 3. LD and DONE are high in cycle 3, and the register file updates at the end of cycle 3.
- Throughput: one instruction per 4 cycles. INSTR_READY is high again in cycle 4.
- Read-after-write: the next instruction's READ occurs no earlier than cycle 5, so it observes the written value. No forwarding is needed.
- Reset values:
  - state IDLE
  - INSTR_READY=1 on the cycle after RESET deasserts
  - SA=SB=DR=0
  - LD=0, D_out=0
  - DONE=0, ERR=0
  - FLAG_Z=0, FLAG_C=0
- RESET mid-instruction, in any state: abort, with no LD pulse afterward. All outputs return to reset values at the next edge.
- INSTR_VALID while not ready: ignored. INSTR is not sampled and the source must hold it.

## Structure
- Package reg_seq_pkg holds:
  - opcode localparams (OP_NOP … OP_SHR)
  - field bit-position constants
  - FSM state enum (S_IDLE, S_READ, S_EXEC, S_WB)
- One sub-module: alu8, combinational. It takes op, a, b, and imm and returns result, zero, and carry.
- The FSM, operand/result registers, and flags live in reg_seq_ctrl.

## Test plan
- Reset, then LDI R3, imm 0x5A:
  - LD=1 with DR=3, D_out=0x5A in cycle 3; DONE=1, FLAG_Z=0.
  - INSTR_READY is low in cycles 1–3.
- Register file model holds R1=0xF0 and R2=0x20. ADD DR=4, SA=1, SB=2:
  - D_out=0x10, FLAG_C=1, FLAG_Z=0.
  - SA=1 and SB=2 are held in cycles 1–3.
- SUB DR=5, SA=2, SB=1 with the same values: D_out=0x30, FLAG_C=1 (borrow). SUB R1−R1: D_out=0x00, FLAG_Z=1, FLAG_C=0.
- Opcode 0xC, then NOP: both give DONE=1 with LD never high. ERR=1 only for 0xC. Flags are unchanged from the prior instruction.
- LDI R6, 0x07, then MOV R7 ← R6 issued with INSTR_VALID held continuously:
  - the second instruction is accepted in cycle 4;
  - it writes D_out=0x07 to DR=7, proving the read-after-write spacing.
- ADD issued, RESET asserted in EXEC:
  - no LD pulse follows;
  - on the next edge all outputs hold reset values and INSTR_READY=1 after RESET deasserts.
